// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer for the 8-bit computer.
// Steps T0..T4 and decodes (step, opcode, flags) into bus-enable and load
// strobes for the PC, MAR, RAM, IR, A, B, ALU, flags and output register.
// Optional feature macro: CONDITIONAL_JUMP_EN enables JC (0x7) and JZ (0x8);
// when undefined both decode as NOP and the flag inputs are ignored.
module control_sequencer #(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       counter_out,
    output logic       CE,
    output logic       jump,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       sum_out,
    output logic       subtract,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam step_t LAST_STEP = step_t'(3'(STEPS - 1));

    step_t step_reg;
    logic  halted_reg;

    // Step counter and halt latch; HLT freezes the counter at T2.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_reg   <= T0;
            halted_reg <= 1'b0;
        end else if (halted_reg) begin
            step_reg   <= step_reg;
        end else if (step_reg == T2 && opcode == 4'hF) begin
            halted_reg <= 1'b1;
        end else if (step_reg == LAST_STEP) begin
            step_reg   <= T0;
        end else begin
            step_reg   <= step_t'(step_reg + 3'd1);
        end
    end

`ifndef CONDITIONAL_JUMP_EN
    // Flags only steer conditional jumps, which are absent in this build.
    logic unused_flags;
    assign unused_flags = carry_flag ^ zero_flag;
`endif

    // Microcode decode; everything is forced low in reset and once halted.
    always_comb begin
        counter_out = 1'b0;
        CE          = 1'b0;
        jump        = 1'b0;
        mar_in      = 1'b0;
        ram_out     = 1'b0;
        ram_in      = 1'b0;
        ir_in       = 1'b0;
        ir_out      = 1'b0;
        a_in        = 1'b0;
        a_out       = 1'b0;
        b_in        = 1'b0;
        sum_out     = 1'b0;
        subtract    = 1'b0;
        flags_in    = 1'b0;
        out_in      = 1'b0;
        if (!reset && !halted_reg) begin
            case (step_reg)
                T0: begin
                    counter_out = 1'b1;
                    mar_in      = 1'b1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    CE      = 1'b1;
                end
                T2: begin
                    case (opcode)
                        4'h1, 4'h2, 4'h3, 4'h4: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        4'h5: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        4'h6: begin
                            ir_out = 1'b1;
                            jump   = 1'b1;
                        end
`ifdef CONDITIONAL_JUMP_EN
                        4'h7: begin
                            ir_out = 1'b1;
                            jump   = carry_flag;
                        end
                        4'h8: begin
                            ir_out = 1'b1;
                            jump   = zero_flag;
                        end
`endif
                        4'hE: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        4'h1: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        4'h2, 4'h3: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        4'h4: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == 4'h2 || opcode == 4'h3) begin
                        sum_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        subtract = (opcode == 4'h3);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt = halted_reg & ~reset;
    assign step = step_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the stimulus process drives one
// cycle at a time and queues the hand-written expected outputs; the monitor
// pops and compares on every falling edge.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       counter_out, CE, jump, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic       a_in, a_out, b_in, sum_out, subtract, flags_in, out_in, halt;
    logic [2:0] step;

    control_sequencer #(.STEPS(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .counter_out(counter_out), .CE(CE), .jump(jump), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .sum_out(sum_out),
        .subtract(subtract), .flags_in(flags_in), .out_in(out_in),
        .halt(halt), .step(step)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] M_CO = 15'h0001, M_CE = 15'h0002, M_J  = 15'h0004;
    localparam logic [14:0] M_MI = 15'h0008, M_RO = 15'h0010, M_RI = 15'h0020;
    localparam logic [14:0] M_II = 15'h0040, M_IO = 15'h0080, M_AI = 15'h0100;
    localparam logic [14:0] M_AO = 15'h0200, M_BI = 15'h0400, M_EO = 15'h0800;
    localparam logic [14:0] M_SU = 15'h1000, M_FI = 15'h2000, M_OI = 15'h4000;
    localparam logic [14:0] F0 = M_CO | M_MI;
    localparam logic [14:0] F1 = M_RO | M_II | M_CE;

`ifdef CONDITIONAL_JUMP_EN
    localparam logic [14:0] CJ_TAKEN = M_IO | M_J;
    localparam logic [14:0] CJ_NOT   = M_IO;
`else
    localparam logic [14:0] CJ_TAKEN = 15'h0000;
    localparam logic [14:0] CJ_NOT   = 15'h0000;
`endif

    wire [14:0] act_mask = {out_in, flags_in, subtract, sum_out, b_in, a_out,
                            a_in, ir_out, ir_in, ram_in, ram_out, mar_in,
                            jump, CE, counter_out};

    typedef struct {
        string       nm;
        logic [18:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one comparison per observed cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [18:0] act;
            e   = q.pop_front();
            act = {step, halt, act_mask};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got step=%0d halt=%b mask=%h, want step=%0d halt=%b mask=%h",
                         e.nm, act[18:16], act[15], act[14:0],
                         e.exp[18:16], e.exp[15], e.exp[14:0]);
            end else begin
                $display("ok   %s: step=%0d halt=%b mask=%h",
                         e.nm, act[18:16], act[15], act[14:0]);
            end
        end
    end

    // Drive one cycle's inputs and queue what the DUT must show in it.
    task automatic cyc(input string nm, input bit rst, input logic [3:0] op,
                       input bit c, input bit z, input logic [2:0] st,
                       input bit h, input logic [14:0] m);
        exp_t e;
        reset      = rst;
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
        e.nm  = nm;
        e.exp = {st, h, m};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A full five-cycle instruction with constant flags.
    task automatic instr(input string nm, input logic [3:0] op, input bit c,
                         input bit z, input logic [14:0] m2,
                         input logic [14:0] m3, input logic [14:0] m4);
        cyc({nm, ".t0"}, 0, op, c, z, 3'd0, 0, F0);
        cyc({nm, ".t1"}, 0, op, c, z, 3'd1, 0, F1);
        cyc({nm, ".t2"}, 0, op, c, z, 3'd2, 0, m2);
        cyc({nm, ".t3"}, 0, op, c, z, 3'd3, 0, m3);
        cyc({nm, ".t4"}, 0, op, c, z, 3'd4, 0, m4);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("rst0", 1, 4'h0, 0, 0, 3'd0, 0, 15'h0);
        cyc("rst1", 1, 4'h0, 0, 0, 3'd0, 0, 15'h0);

        instr("nop",  4'h0, 0, 0, 15'h0, 15'h0, 15'h0);
        instr("add",  4'h2, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI);
        instr("sub",  4'h3, 0, 0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI | M_SU);
        instr("lda",  4'h1, 0, 0, M_IO | M_MI, M_RO | M_AI, 15'h0);
        instr("sta",  4'h4, 0, 0, M_IO | M_MI, M_AO | M_RI, 15'h0);
        instr("ldi",  4'h5, 0, 0, M_IO | M_AI, 15'h0, 15'h0);
        instr("jmp",  4'h6, 0, 0, M_IO | M_J, 15'h0, 15'h0);
        instr("jz1",  4'h8, 0, 1, CJ_TAKEN, 15'h0, 15'h0);
        instr("jz0",  4'h8, 1, 0, CJ_NOT, 15'h0, 15'h0);
        instr("jc1",  4'h7, 1, 0, CJ_TAKEN, 15'h0, 15'h0);
        instr("jc0",  4'h7, 0, 1, CJ_NOT, 15'h0, 15'h0);

        // Carry rises only after T2: the jump must not happen late.
        cyc("jclate.t0", 0, 4'h7, 0, 0, 3'd0, 0, F0);
        cyc("jclate.t1", 0, 4'h7, 0, 0, 3'd1, 0, F1);
        cyc("jclate.t2", 0, 4'h7, 0, 0, 3'd2, 0, CJ_NOT);
        cyc("jclate.t3", 0, 4'h7, 1, 1, 3'd3, 0, 15'h0);
        cyc("jclate.t4", 0, 4'h7, 1, 1, 3'd4, 0, 15'h0);

        instr("out",  4'hE, 0, 0, M_AO | M_OI, 15'h0, 15'h0);
        instr("op_a", 4'hA, 1, 1, 15'h0, 15'h0, 15'h0);

        // Reset during T3 of LDA abandons it.
        cyc("ldarst.t0", 0, 4'h1, 0, 0, 3'd0, 0, F0);
        cyc("ldarst.t1", 0, 4'h1, 0, 0, 3'd1, 0, F1);
        cyc("ldarst.t2", 0, 4'h1, 0, 0, 3'd2, 0, M_IO | M_MI);
        cyc("ldarst.t3", 1, 4'h1, 0, 0, 3'd3, 0, 15'h0);
        cyc("ldarst.rel", 0, 4'h1, 0, 0, 3'd0, 0, F0);
        cyc("ldarst.t1b", 0, 4'h0, 0, 0, 3'd1, 0, F1);
        cyc("ldarst.t2b", 0, 4'h0, 0, 0, 3'd2, 0, 15'h0);
        cyc("ldarst.t3b", 0, 4'h0, 0, 0, 3'd3, 0, 15'h0);
        cyc("ldarst.t4b", 0, 4'h0, 0, 0, 3'd4, 0, 15'h0);

        // HLT latches and holds regardless of the opcode afterwards.
        cyc("hlt.t0", 0, 4'hF, 0, 0, 3'd0, 0, F0);
        cyc("hlt.t1", 0, 4'hF, 0, 0, 3'd1, 0, F1);
        cyc("hlt.t2", 0, 4'hF, 0, 0, 3'd2, 0, 15'h0);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halted%0d", i), 0, (i < 10) ? 4'hF : 4'h2,
                1, 1, 3'd2, 1, 15'h0);
        end
        cyc("hlt.rst", 1, 4'h2, 0, 0, 3'd2, 0, 15'h0);
        cyc("hlt.rel", 0, 4'h2, 0, 0, 3'd0, 0, F0);
        cyc("hlt.t1b", 0, 4'h2, 0, 0, 3'd1, 0, F1);
        cyc("hlt.t2b", 0, 4'h2, 0, 0, 3'd2, 0, M_IO | M_MI);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
